mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//  Multi-cycle 16x16->32 shift-add multiplier sequencer for the EX stage.
//  Owns no adder; each RUN cycle it drives the shared 16-bit add/sub unit and consumes its sum/carry.
//  Exposes a start/busy/done handshake to the pipeline control, which stalls EX while busy=1.
// PARAMETERS
//  WIDTH  16  operand width; product is 2*WIDTH. Only 16 is supported in this revision.
// PORTS
//  clk         in   1   system clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  start       in   1   request a multiply; sampled only when busy=0
//  op_a        in   16  multiplicand, captured on accepted start
//  op_b        in   16  multiplier, captured on accepted start
//  op_signed   in   1   treat operands as two's complement (honoured only with MULT_SIGNED_EN)
//  busy        out  1   1 in RUN state; pipeline must hold op_* and start
//  done        out  1   one-cycle pulse when prod is valid
//  prod        out  32  product; held stable until the next accepted start or rst
//  prod_hi_nz  out  1   prod[31:16] != 0 (16-bit result overflow indicator), valid with prod
//  add_a       out  16  shared adder operand A (accumulator high half)
//  add_b       out  16  shared adder operand B (multiplicand)
//  add_isAdd   out  1   1 = add; held 1 in RUN, 0 otherwise
//  add_sum     in   16  shared adder result (combinational, same cycle)
//  add_cout    in   1   shared adder carry out
// BEHAVIOUR
//  - States: IDLE, RUN, DONE. Reset: state=IDLE, busy=0, done=0, prod=0, prod_hi_nz=0, count=0.
//  - IDLE/DONE + start=1: latch mcand=op_a, {acc,mplr}={16'h0,op_b}, count=15 -> RUN.
//  - DONE with start=0 -> IDLE. done=1 only in DONE; busy=1 only in RUN.
//  - RUN, every cycle: add_a=acc, add_b=mcand, add_isAdd=1.
//    if mplr[0]: {acc,mplr} <= {add_cout, add_sum, mplr} >> 1
//    else:       {acc,mplr} <= {1'b0,    acc,     mplr} >> 1
//    count decrements; at count==0 the update completes and state -> DONE.
//  - prod/prod_hi_nz load on the RUN->DONE edge from final {acc,mplr}.
//  - Fixed latency: start accepted at cycle N -> done=1 at cycle N+17; no early exit on zero operands.
//  - start while busy=1: ignored, no state change, no error.
//  - Back-to-back: start in the DONE cycle is accepted; the next done arrives 17 cycles later.
//  - Outside RUN: add_a=0, add_b=0, add_isAdd=0, so the shared adder is free to another user.
//  - rst mid-RUN: next cycle IDLE, busy=0, prod=0; the partial result is discarded.
//  - Arithmetic unsigned; the adder carry is bit 16 of the partial sum. No overflow is possible in 32 bits.
// CONFIGURATION
//  MULT_SIGNED_EN defined:
//   - On accept with op_signed=1, latch |op_a| and |op_b| using a local two's-complement negate, not the shared adder.
//   - Record sign = op_a[15]^op_b[15]; on RUN->DONE, prod = sign ? -{acc,mplr} : {acc,mplr}.
//   - |0x8000| = 0x8000 treated as unsigned magnitude; the result is exact.
//  MULT_SIGNED_EN undefined: op_signed ignored, all operands unsigned, no negate logic synthesized.
//  Latency is identical in both builds.
// TESTING
//  1. rst=1 for 2 cycles -> busy=0, done=0, prod=0, add_isAdd=0.
//  2. start, op_a=3, op_b=5 at cycle 0 -> busy cycles 1..16, done=1 at 17, prod=0x0000000F, prod_hi_nz=0.
//  3. op_a=0xFFFF, op_b=0xFFFF -> prod=0xFFFE0001, prod_hi_nz=1; carry path exercised.
//  4. start 2*2 accepted; start with 7*7 at cycle 5 -> ignored; prod=0x00000004 at cycle 17.
//  5. start 100*100; rst at cycle 8 -> cycle 9 busy=0, prod=0, no done; a new start 4*4 gives prod=0x10 at +17.
//  6. MULT_SIGNED_EN, op_signed=1: -3(0xFFFD)*7 -> prod=0xFFFFFFEB; start 0x8000*0x8000 issued in the DONE cycle -> prod=0x40000000.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle 16x16->32 shift-add multiplier sequencer driving a shared external adder.
// Optional signed operand handling is enabled with `define MULT_SIGNED_EN.
module mult_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 op_signed,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 prod_hi_nz,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_isAdd,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mplr;
    logic [2*WIDTH-1:0] next_am;
    logic [2*WIDTH-1:0] final_prod;
    logic               accept;

    assign accept = start && (state != RUN);

`ifdef MULT_SIGNED_EN
    logic sign;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_prod(input logic [2*WIDTH-1:0] v);
        return (~v) + (2*WIDTH)'(1);
    endfunction
`else
    logic unused_signed;
    assign unused_signed = op_signed;
`endif

    // The adder is only claimed while RUN; otherwise its inputs are parked at zero.
    assign add_a     = (state == RUN) ? acc   : '0;
    assign add_b     = (state == RUN) ? mcand : '0;
    assign add_isAdd = (state == RUN);

    always_comb begin
        next_am = {1'b0, acc, mplr[WIDTH-1:1]};
        if (mplr[0]) begin
            next_am = {add_cout, add_sum, mplr[WIDTH-1:1]};
        end
`ifdef MULT_SIGNED_EN
        final_prod = sign ? negate_prod(next_am) : next_am;
`else
        final_prod = next_am;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            prod       <= '0;
            prod_hi_nz <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                RUN: begin
                    count <= count - CW'(1);
                    if (count == '0) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        prod       <= final_prod;
                        prod_hi_nz <= (final_prod[2*WIDTH-1:WIDTH] != '0);
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        count <= LAST;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded on an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
`ifdef MULT_SIGNED_EN
            if (op_signed) begin
                mcand <= magnitude(op_a);
                mplr  <= magnitude(op_b);
                sign  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            end else begin
                mcand <= op_a;
                mplr  <= op_b;
                sign  <= 1'b0;
            end
`else
            mcand <= op_a;
            mplr  <= op_b;
`endif
            acc <= '0;
        end else if (state == RUN) begin
            {acc, mplr} <= next_am;
        end
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed, randomized, ignore, mid-run reset and back-to-back cases.
`timescale 1ns/1ps
module tb_mult_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_signed;
    logic        busy;
    logic        done;
    logic [31:0] prod;
    logic        prod_hi_nz;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_isAdd;
    logic [15:0] add_sum;
    logic        add_cout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Shared add/sub unit as seen by the sequencer
    always_comb begin
        if (add_isAdd) {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};
        else           {add_cout, add_sum} = {1'b0, add_a} - {1'b0, add_b};
    end

    mult_seq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .op_signed(op_signed), .busy(busy), .done(done), .prod(prod),
        .prod_hi_nz(prod_hi_nz), .add_a(add_a), .add_b(add_b),
        .add_isAdd(add_isAdd), .add_sum(add_sum), .add_cout(add_cout)
    );

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] r;
        r = {16'h0, a} * {16'h0, b};
`ifdef MULT_SIGNED_EN
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            r  = sa * sb;
        end
`endif
        return r;
    endfunction

    // Issue one start and follow the operation up to done (or a 40-cycle bound).
    // Returns the done cycle index (0 on timeout), busy cycle count and adder usage flag.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output int done_k, output int busy_n, output bit adder_ok);
        done_k   = 0;
        busy_n   = 0;
        adder_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; op_signed = s;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) begin
                busy_n++;
                if (add_isAdd !== 1'b1) adder_ok = 1'b0;
            end
            if (done) begin
                done_k = k;
                if (add_isAdd !== 1'b0 || add_a !== 16'h0 || add_b !== 16'h0) adder_ok = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_signed = 1'b0;
        idle_cycles(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", done); end
        checks++; if (prod !== 32'h0) begin errors++; $display("FAIL reset_prod got=%h want=0", prod); end
        checks++; if (add_isAdd !== 1'b0) begin errors++; $display("FAIL reset_isadd got=%0b want=0", add_isAdd); end
        checks++; if (prod_hi_nz !== 1'b0) begin errors++; $display("FAIL reset_hinz got=%0b want=0", prod_hi_nz); end
        @(negedge clk); rst = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_directed;
        logic [15:0] as [2] = '{16'h0003, 16'hFFFF};
        logic [15:0] bs [2] = '{16'h0005, 16'hFFFF};
        int dk, bn;
        bit aok;
        logic [31:0] exp;
        for (int i = 0; i < 2; i++) begin
            run_op(as[i], bs[i], 1'b0, dk, bn, aok);
            exp = model(as[i], bs[i], 1'b0);
            checks++; if (dk != 17) begin errors++; $display("FAIL dir_latency[%0d] got=%0d want=17", i, dk); end
            checks++; if (bn != 16) begin errors++; $display("FAIL dir_busy[%0d] got=%0d want=16", i, bn); end
            checks++; if (prod !== exp) begin errors++; $display("FAIL dir_prod[%0d] got=%h want=%h", i, prod, exp); end
            checks++; if (prod_hi_nz !== (exp[31:16] != 0)) begin errors++; $display("FAIL dir_hinz[%0d] got=%0b want=%0b", i, prod_hi_nz, exp[31:16] != 0); end
            checks++; if (!aok) begin errors++; $display("FAIL dir_adder[%0d] got=bad want=ok", i); end
            idle_cycles(2);
            checks++; if (prod !== exp) begin errors++; $display("FAIL dir_hold[%0d] got=%h want=%h", i, prod, exp); end
        end
    endtask

    task automatic test_random;
        int dk, bn;
        bit aok;
        logic [15:0] a, b;
        logic s;
        logic [31:0] exp;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 6 == 0) a = 16'h0;
            if (i % 6 == 1) b = 16'h8000;
            s = 1'($urandom);
            run_op(a, b, s, dk, bn, aok);
            exp = model(a, b, s);
            checks++; if (dk != 17) begin errors++; $display("FAIL rnd_latency[%0d] got=%0d want=17", i, dk); end
            checks++; if (prod !== exp) begin errors++; $display("FAIL rnd_prod[%0d] a=%h b=%h s=%0b got=%h want=%h", i, a, b, s, prod, exp); end
            checks++; if (prod_hi_nz !== (exp[31:16] != 0)) begin errors++; $display("FAIL rnd_hinz[%0d] got=%0b want=%0b", i, prod_hi_nz, exp[31:16] != 0); end
            idle_cycles(i % 3);
        end
    endtask

    task automatic test_ignore_busy;
        int dk = 0;
        @(negedge clk);
        start = 1'b1; op_a = 16'd2; op_b = 16'd2; op_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin start = 1'b1; op_a = 16'd7; op_b = 16'd7; end
            if (k == 6) start = 1'b0;
            if (done) begin dk = k; break; end
            @(posedge clk); #1;
        end
        checks++; if (dk != 17) begin errors++; $display("FAIL ign_latency got=%0d want=17", dk); end
        checks++; if (prod !== 32'h4) begin errors++; $display("FAIL ign_prod got=%h want=00000004", prod); end
        idle_cycles(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got=%0b want=0", busy); end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_run;
        int dk, bn;
        bit aok;
        bit saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; op_a = 16'd100; op_b = 16'd100; op_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
        checks++; if (prod !== 32'h0) begin errors++; $display("FAIL rstmid_prod got=%h want=0", prod); end
        for (int k = 0; k < 20; k++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL rstmid_nodone got=1 want=0"); end
        run_op(16'd4, 16'd4, 1'b0, dk, bn, aok);
        checks++; if (dk != 17) begin errors++; $display("FAIL rstmid_latency got=%0d want=17", dk); end
        checks++; if (prod !== 32'h10) begin errors++; $display("FAIL rstmid_prod2 got=%h want=00000010", prod); end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back;
        int dk, bn;
        bit aok;
        logic [31:0] exp;
        run_op(16'hFFFD, 16'h0007, 1'b1, dk, bn, aok);
        exp = model(16'hFFFD, 16'h0007, 1'b1);
        checks++; if (prod !== exp) begin errors++; $display("FAIL b2b_prod0 got=%h want=%h", prod, exp); end
        // run_op starts from the DONE cycle it returned in
        run_op(16'h8000, 16'h8000, 1'b1, dk, bn, aok);
        exp = model(16'h8000, 16'h8000, 1'b1);
        checks++; if (dk != 17) begin errors++; $display("FAIL b2b_latency got=%0d want=17", dk); end
        checks++; if (prod !== exp) begin errors++; $display("FAIL b2b_prod1 got=%h want=%h", prod, exp); end
        checks++; if (prod_hi_nz !== 1'b1) begin errors++; $display("FAIL b2b_hinz got=%0b want=1", prod_hi_nz); end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
